// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Slot record, register-address width helper and saturating increment.
package hazard_pkg;

    localparam int MAX_RA_W = 8;

    typedef struct packed {
        logic                valid;
        logic                wen;
        logic                is_load;
        logic [MAX_RA_W-1:0] dst;
    } slot_t;

    function automatic int ra_w(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    function automatic logic [63:0] sat_inc(
        input logic [63:0] value,
        input int          width
    );
        logic [63:0] top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= top) ? top : value + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Priority producer search for one source operand: youngest eligible
// slot wins; a load still short of its data slot raises pending.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 2
) (
    input  slot_t [DEPTH-1:0]        slots,
    input  logic  [DEPTH-1:0]        flush_mask,
    input  logic  [RA_W-1:0]         src,
    input  logic                     used,
    input  logic  [DEPTH*DATA_W-1:0] stage_data,
    input  logic  [DATA_W-1:0]       rf_data,
    output logic  [DATA_W-1:0]       opnd,
    output logic                     hit,
    output logic                     pending
);

    logic found;
    logic ready;
    int   sel;

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        found = 1'b0;
        ready = 1'b0;
        sel   = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots[i].valid && slots[i].wen && used &&
                !flush_mask[i] &&
                slots[i].dst == MAX_RA_W'(src)) begin
                found = 1'b1;
                ready = !slots[i].is_load || (i >= LOAD_LAT);
                sel   = i;
            end
        end
        hit     = found & ready;
        pending = found & ~ready;
        opnd    = hit ? stage_data[sel*DATA_W +: DATA_W] : rf_data;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Operand forwarding and load-use stall unit with a shift scoreboard.
// Optional statistics counters: define HAZARD_STATS_EN.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NREGS    = 4,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int RA_W     = ra_w(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic                     issue_is_load,
    input  logic [RA_W-1:0]          issue_dst,
    input  logic [RA_W-1:0]          src1,
    input  logic [RA_W-1:0]          src2,
    input  logic                     src1_used,
    input  logic                     src2_used,
    input  logic                     issue_kill,
    input  logic [DEPTH-1:0]         flush_mask,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    input  logic [DATA_W-1:0]        rf_data1,
    input  logic [DATA_W-1:0]        rf_data2,
    output logic                     issue_ready,
    output logic                     stall,
    output logic [DATA_W-1:0]        opnd1,
    output logic [DATA_W-1:0]        opnd2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic                     commit_valid,
    output logic [RA_W-1:0]          commit_dst,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [CNT_W-1:0]         stall_count,
    output logic [CNT_W-1:0]         bubble_count
);

    slot_t [DEPTH-1:0] slots;
    slot_t             in_slot;
    logic              pend1;
    logic              pend2;
    logic              take;

    fwd_select #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .RA_W    (RA_W)
    ) u_fwd1 (
        .slots     (slots),
        .flush_mask(flush_mask),
        .src       (src1),
        .used      (src1_used),
        .stage_data(stage_data),
        .rf_data   (rf_data1),
        .opnd      (opnd1),
        .hit       (fwd1_hit),
        .pending   (pend1)
    );

    fwd_select #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .RA_W    (RA_W)
    ) u_fwd2 (
        .slots     (slots),
        .flush_mask(flush_mask),
        .src       (src2),
        .used      (src2_used),
        .stage_data(stage_data),
        .rf_data   (rf_data2),
        .opnd      (opnd2),
        .hit       (fwd2_hit),
        .pending   (pend2)
    );

    // Kill takes priority: a killed issue never holds decode.
    assign stall       = issue_valid & ~issue_kill & (pend1 | pend2);
    assign issue_ready = ~stall;
    assign take        = issue_valid & ~stall & ~issue_kill;

    always_comb begin
        in_slot = '0;
        if (take) begin
            in_slot.valid   = 1'b1;
            in_slot.wen     = issue_wen;
            in_slot.is_load = issue_is_load;
            in_slot.dst     = MAX_RA_W'(issue_dst);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slots        <= '0;
            commit_valid <= 1'b0;
            commit_dst   <= '0;
        end else begin
            commit_valid <= slots[DEPTH-1].valid & slots[DEPTH-1].wen &
                            ~flush_mask[DEPTH-1];
            commit_dst   <= slots[DEPTH-1].dst[RA_W-1:0];
            for (int i = DEPTH - 1; i >= 1; i--) begin
                slots[i] <= flush_mask[i-1] ? '0 : slots[i-1];
            end
            slots[0] <= in_slot;
        end
    end

    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = slots[i].valid;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (stall) begin
                stall_q <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
            end
            if (!take) begin
                bubble_q <= CNT_W'(sat_inc(64'(bubble_q), CNT_W));
            end
        end
    end

    assign stall_count  = stall_q;
    assign bubble_count = bubble_q;
`else
    assign stall_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

- Parametrised operand-forwarding and load-use stall unit for the in-order pipelined processor.
- Generalises the fixed two-mux writeback bypass to `NREGS` registers, `DATA_W`-bit data and `DEPTH` in-flight stages, with a configurable load latency.
- Tracks every issued instruction in a shift scoreboard, selects the youngest producer for each source operand, and stalls issue when that producer's data is not ready yet.
- Sits between the decode/register-read stage and the ALU/memory/writeback stages.

## Interface
- `DATA_W`, 8, datapath width
- `NREGS`, 4, architectural register count; `RA_W = $clog2(NREGS)`
- `DEPTH`, 3, in-flight slots between issue and register-file commit (≥2)
- `LOAD_LAT`, 1, slot index at which load data becomes valid (1..DEPTH-1)
- `CNT_W`, 16, statistics counter width
- `clock` in 1 — clock
- `reset` in 1 — reset, asynchronous, active-high
- `issue_valid` in 1 — decode presents an instruction
- `issue_wen` in 1 — instruction writes a register
- `issue_is_load` in 1 — instruction is a load
- `issue_dst` in RA_W — destination register
- `src1`, `src2` in RA_W — source registers
- `src1_used`, `src2_used` in 1 — the source is actually read
- `issue_kill` in 1 — discard the current issue (branch taken)
- `flush_mask` in DEPTH — per-slot kill, applied this edge
- `stage_data` in DEPTH*DATA_W — result visible in slot i, at bits [i*DATA_W +: DATA_W]
- `rf_data1`, `rf_data2` in DATA_W — register-file read data
- `issue_ready` out 1 — `~stall`
- `stall` out 1 — load-use hazard, combinational
- `opnd1`, `opnd2` out DATA_W — forwarded or register-file operand
- `fwd1_hit`, `fwd2_hit` out 1 — operand taken from `stage_data`
- `commit_valid` out 1 — registered; slot DEPTH-1 commits (drives `RFWrite`)
- `commit_dst` out RA_W — registered
- `slot_valid` out DEPTH — registered; scoreboard occupancy
- `stall_count`, `bubble_count` out CNT_W — statistics

## Operation
- Each slot holds {valid, wen, is_load, dst}. Slot 0 is the youngest instruction.
- Every clock edge (the back end never stalls):
  - Slot i moves to slot i+1.
  - Slot DEPTH-1 retires into `commit_valid`/`commit_dst` (valid & wen).
  - Slot 0 loads the issue if `issue_valid & ~stall & ~issue_kill`; otherwise a bubble (valid=0).
- `flush_mask[i]` clears slot i's contents before the shift. A flushed slot never forwards, stalls or commits.
- A slot is eligible as a producer for srcN when: `valid & wen & dst==srcN & srcN_used & ~flush_mask[i]`.
- Producer selection: lowest-index eligible slot (youngest wins).
- Producer data is ready when `~is_load`, or when `is_load` and slot index ≥ LOAD_LAT.
- Eligible producer, ready: `opndN = stage_data[slot]`, `fwdN_hit = 1`.
- Eligible producer, not ready: `stall = 1`; `opndN` is don't-care.
- No eligible producer: `opndN = rf_dataN`, `fwdN_hit = 0`.
- `stall` is qualified by `issue_valid`; `issue_kill` forces `stall = 0`.

## Timing
- Operand path is fully combinational: zero latency from `src*` and `stage_data` to `opnd*`.
- Issue to commit: DEPTH+1 edges. Commit to register file: data appears at next edge.
- A load followed immediately by a dependent instruction stalls LOAD_LAT cycles; the dependent then forwards from slot LOAD_LAT.
- Reset (any time, including mid-stall):
  - All slots invalid, `commit_valid = 0`, `commit_dst = 0`, counters 0.
  - Therefore `stall = 0` and `fwd*_hit = 0`, and `opnd* = rf_data*`.
- Simultaneous events:
  - flush of the stalling producer plus issue in the same cycle → no stall; operand comes from an older slot or the RF.
  - kill plus stall → kill wins, a bubble is inserted.
  - src1 == src2 → both operands use the same producer.
- Counters saturate at all-ones and never wrap.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_count` increments on each cycle with `stall`.
  - `bubble_count` increments on each edge that loads a bubble into slot 0.
- `HAZARD_STATS_EN` undefined: both counter outputs are constant 0, with no counter flops.

## Structure
- Shared package `hazard_pkg`:
  - slot struct typedef {valid, wen, is_load, dst}
  - `RA_W` helper
  - counter saturate function
- One sub-module, `fwd_select`: the priority producer search for a single operand, instantiated twice.

## Test plan
- **Reset mid-stall.** Put a load in slot 0 with a dependent issuing, then assert `reset` → `stall = 0`, `slot_valid = 0`, `opnd1 = rf_data1` in the same cycle.
- **ALU chain (DEPTH=3).** Issue ADD r1, then ADD reading r1 with `stage_data[0] = 8'h5A` → `opnd1 = 8'h5A`, `fwd1_hit = 1`, no stall.
- **Load-use (LOAD_LAT=1).** Issue LOAD r2, then a reader of r2 → exactly 1 stall cycle. Next cycle `opnd2 = stage_data[1]`. `stall_count = 1`, `bubble_count = 1`.
- **Youngest wins.** Writes to r3 sit in slots 0 and 2 with data 8'h11/8'h22 → `opnd = 8'h11`.
- **Flush.** A producer of r0 sits in slot 1; set `flush_mask = 3'b010` → `fwd_hit = 0`, `opnd = rf_data`; three edges later `commit_valid` stays 0.
- **Saturation.** With `CNT_W = 4`, hold a stall for 20 cycles → `stall_count = 4'hF`.
